// File: rtl/nmr_seq_pkg.sv
// Shared definitions for the NMR scan sequencer: FSM state encoding, default widths, handshake timeout.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package nmr_seq_pkg;

   localparam int SCAN_CNT_WIDTH_DEF   = 16;
   localparam int REP_DLY_WIDTH_DEF    = 32;
   localparam int SAMPLE_CNT_WIDTH_DEF = 32;
   localparam int ACK_TIMEOUT_DEF      = 64;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LAUNCH    = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_CHECK     = 3'd4,
      ST_REP_DELAY = 3'd5,
      ST_DONE      = 3'd6
   } seq_state_t;

   // ADC beats are accepted from controller acknowledge through the check cycle,
   // so late pipeline beats that trail the FSMSTAT fall still land in the right scan.
   function automatic logic in_beat_window(input seq_state_t st);
      return (st == ST_WAIT_BUSY) || (st == ST_WAIT_DONE) || (st == ST_CHECK);
   endfunction

endpackage

// File: rtl/nmr_beat_counter.sv
// Saturating counter of ADC_DATA_VALID beats for one scan; cleared at each launch.
// Latency: o_total is combinational and already includes the beat presented this cycle.
// Backpressure: none; beats outside the enable window are dropped.
module nmr_beat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic             i_beat,
   output logic [WIDTH-1:0] o_total
);

   logic [WIDTH-1:0] r_count;
   logic             w_inc;

   // A beat counts only inside the window and the count sticks at all-ones
   assign w_inc   = i_en & i_beat & ~(&r_count);
   assign o_total = w_inc ? (r_count + WIDTH'(1)) : r_count;

   // Running per-scan count, cleared by reset or at scan launch
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clr) begin
         r_count <= '0;
      end else begin
         r_count <= o_total;
      end
   end

endmodule

// File: rtl/nmr_scan_sequencer.sv
// Multi-scan sequencer driving NMR_Controller: one START per scan, phase cycling, repetition delay, beat check.
// Latency: NMR_START asserted in the cycle after SEQ_START; next NMR_START SCAN_REP_DELAY+2 cycles after FSMSTAT falls.
// Backpressure: SEQ_START ignored while busy; SEQ_ABORT never cuts a controller run short.
module nmr_scan_sequencer
   import nmr_seq_pkg::*;
#(
   parameter int SCAN_CNT_WIDTH   = SCAN_CNT_WIDTH_DEF,
   parameter int REP_DLY_WIDTH    = REP_DLY_WIDTH_DEF,
   parameter int SAMPLE_CNT_WIDTH = SAMPLE_CNT_WIDTH_DEF,
   parameter int ACK_TIMEOUT      = ACK_TIMEOUT_DEF
) (
   input  logic                        PULSEPROG_CLK,
   input  logic                        RESET_N,
   input  logic                        SEQ_START,
   input  logic                        SEQ_ABORT,
   input  logic [SCAN_CNT_WIDTH-1:0]   NUM_SCANS,
   input  logic [REP_DLY_WIDTH-1:0]    SCAN_REP_DELAY,
   input  logic                        PHASE_CYCLE_EN,
   input  logic [SAMPLE_CNT_WIDTH-1:0] EXPECTED_SAMPLES,
   output logic                        NMR_START,
   input  logic                        NMR_FSMSTAT,
   input  logic                        ADC_DATA_VALID,
   output logic                        PHASE_CYCLE,
   output logic [SCAN_CNT_WIDTH-1:0]   SCAN_IDX,
   output logic                        SEQ_BUSY,
   output logic                        SEQ_DONE,
   output logic                        SEQ_ABORTED,
   output logic                        SAMPLE_ERR,
   output logic                        TIMEOUT_ERR
);

   localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TMO_W-1:0]          TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
   localparam logic [SCAN_CNT_WIDTH-1:0] SCAN_ONE = SCAN_CNT_WIDTH'(1);
   localparam logic [REP_DLY_WIDTH-1:0]  DLY_ONE  = REP_DLY_WIDTH'(1);

   seq_state_t                  r_state;
   logic [SCAN_CNT_WIDTH-1:0]   r_num_scans;
   logic [REP_DLY_WIDTH-1:0]    r_rep_dly;
   logic                        r_phase_en;
   logic [SAMPLE_CNT_WIDTH-1:0] r_expected;
   logic [SCAN_CNT_WIDTH-1:0]   r_scan_idx;
   logic [REP_DLY_WIDTH-1:0]    r_dly_cnt;
   logic [TMO_W-1:0]            r_tmo_cnt;
   logic                        r_abort_pend;
   logic                        r_nmr_start;
   logic                        r_phase;
   logic                        r_busy;
   logic                        r_seq_done;
   logic                        r_aborted;
   logic                        r_sample_err;
   logic                        r_timeout_err;

   logic [SAMPLE_CNT_WIDTH-1:0] w_beat_total;
   logic                        w_abort;
   logic                        w_last_scan;
   logic [SCAN_CNT_WIDTH-1:0]   w_idx_nxt;

   // An abort raised in the same cycle as the decision point counts as pending
   assign w_abort     = SEQ_ABORT | r_abort_pend;
   assign w_last_scan = (r_scan_idx == (r_num_scans - SCAN_ONE));
   assign w_idx_nxt   = r_scan_idx + SCAN_ONE;

   nmr_beat_counter #(
      .WIDTH (SAMPLE_CNT_WIDTH)
   ) u_beat_cnt (
      .i_clk   (PULSEPROG_CLK),
      .i_rst_n (RESET_N),
      .i_clr   (r_state == ST_LAUNCH),
      .i_en    (in_beat_window(r_state)),
      .i_beat  (ADC_DATA_VALID),
      .o_total (w_beat_total)
   );

   // Sequencer FSM; every output is a register written alongside the state it belongs to
   always_ff @(posedge PULSEPROG_CLK) begin
      if (!RESET_N) begin
         r_state       <= ST_IDLE;
         r_num_scans   <= '0;
         r_rep_dly     <= '0;
         r_phase_en    <= 1'b0;
         r_expected    <= '0;
         r_scan_idx    <= '0;
         r_dly_cnt     <= '0;
         r_tmo_cnt     <= '0;
         r_abort_pend  <= 1'b0;
         r_nmr_start   <= 1'b0;
         r_phase       <= 1'b0;
         r_busy        <= 1'b0;
         r_seq_done    <= 1'b0;
         r_aborted     <= 1'b0;
         r_sample_err  <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_nmr_start <= 1'b0;
         r_seq_done  <= 1'b0;
         if ((r_state != ST_IDLE) && SEQ_ABORT) begin
            r_abort_pend <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (SEQ_START) begin
                  r_num_scans   <= NUM_SCANS;
                  r_rep_dly     <= SCAN_REP_DELAY;
                  r_phase_en    <= PHASE_CYCLE_EN;
                  r_expected    <= EXPECTED_SAMPLES;
                  r_scan_idx    <= '0;
                  r_phase       <= 1'b0;
                  r_abort_pend  <= 1'b0;
                  r_aborted     <= 1'b0;
                  r_sample_err  <= 1'b0;
                  r_timeout_err <= 1'b0;
                  r_busy        <= 1'b1;
                  if (NUM_SCANS == '0) begin
                     r_state    <= ST_DONE;
                     r_seq_done <= 1'b1;
                  end else begin
                     r_state     <= ST_LAUNCH;
                     r_nmr_start <= 1'b1;
                  end
               end
            end
            ST_LAUNCH: begin
               r_tmo_cnt <= '0;
               r_state   <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (NMR_FSMSTAT) begin
                  r_state <= ST_WAIT_DONE;
               end else if (r_tmo_cnt == TMO_LAST) begin
                  r_timeout_err <= 1'b1;
                  r_aborted     <= w_abort;
                  r_seq_done    <= 1'b1;
                  r_state       <= ST_DONE;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
               end
            end
            ST_WAIT_DONE: begin
               if (!NMR_FSMSTAT) begin
                  r_state <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (w_beat_total != r_expected) begin
                  r_sample_err <= 1'b1;
               end
               if (w_abort || w_last_scan) begin
                  r_aborted  <= w_abort;
                  r_seq_done <= 1'b1;
                  r_state    <= ST_DONE;
               end else begin
                  r_scan_idx <= w_idx_nxt;
                  r_phase    <= r_phase_en & w_idx_nxt[0];
                  r_dly_cnt  <= r_rep_dly;
                  if (r_rep_dly == '0) begin
                     r_nmr_start <= 1'b1;
                     r_state     <= ST_LAUNCH;
                  end else begin
                     r_state <= ST_REP_DELAY;
                  end
               end
            end
            ST_REP_DELAY: begin
               if (w_abort) begin
                  r_aborted  <= 1'b1;
                  r_seq_done <= 1'b1;
                  r_state    <= ST_DONE;
               end else if (r_dly_cnt == DLY_ONE) begin
                  r_nmr_start <= 1'b1;
                  r_state     <= ST_LAUNCH;
               end else begin
                  r_dly_cnt <= r_dly_cnt - DLY_ONE;
               end
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign NMR_START   = r_nmr_start;
   assign PHASE_CYCLE = r_phase;
   assign SCAN_IDX    = r_scan_idx;
   assign SEQ_BUSY    = r_busy;
   assign SEQ_DONE    = r_seq_done;
   assign SEQ_ABORTED = r_aborted;
   assign SAMPLE_ERR  = r_sample_err;
   assign TIMEOUT_ERR = r_timeout_err;

endmodule

// File: tb/tb_nmr_scan_sequencer.sv
// Self-checking bench for nmr_scan_sequencer with a behavioural NMR_Controller model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_nmr_scan_sequencer;

   localparam int ACK = 64;

   logic        PULSEPROG_CLK;
   logic        RESET_N;
   logic        SEQ_START;
   logic        SEQ_ABORT;
   logic [15:0] NUM_SCANS;
   logic [31:0] SCAN_REP_DELAY;
   logic        PHASE_CYCLE_EN;
   logic [31:0] EXPECTED_SAMPLES;
   logic        NMR_START;
   logic        NMR_FSMSTAT;
   logic        ADC_DATA_VALID;
   logic        PHASE_CYCLE;
   logic [15:0] SCAN_IDX;
   logic        SEQ_BUSY;
   logic        SEQ_DONE;
   logic        SEQ_ABORTED;
   logic        SAMPLE_ERR;
   logic        TIMEOUT_ERR;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   int start_q[$];
   int phase_q[$];
   int idx_q[$];
   int done_q[$];
   int fall_q[$];
   int busy_cycles = 0;
   int err_first   = -1;

   int beat_plan[8];
   int mdl_scan  = 0;
   bit mdl_noack = 1'b0;

   nmr_scan_sequencer #(
      .SCAN_CNT_WIDTH   (16),
      .REP_DLY_WIDTH    (32),
      .SAMPLE_CNT_WIDTH (32),
      .ACK_TIMEOUT      (ACK)
   ) dut (
      .PULSEPROG_CLK    (PULSEPROG_CLK),
      .RESET_N          (RESET_N),
      .SEQ_START        (SEQ_START),
      .SEQ_ABORT        (SEQ_ABORT),
      .NUM_SCANS        (NUM_SCANS),
      .SCAN_REP_DELAY   (SCAN_REP_DELAY),
      .PHASE_CYCLE_EN   (PHASE_CYCLE_EN),
      .EXPECTED_SAMPLES (EXPECTED_SAMPLES),
      .NMR_START        (NMR_START),
      .NMR_FSMSTAT      (NMR_FSMSTAT),
      .ADC_DATA_VALID   (ADC_DATA_VALID),
      .PHASE_CYCLE      (PHASE_CYCLE),
      .SCAN_IDX         (SCAN_IDX),
      .SEQ_BUSY         (SEQ_BUSY),
      .SEQ_DONE         (SEQ_DONE),
      .SEQ_ABORTED      (SEQ_ABORTED),
      .SAMPLE_ERR       (SAMPLE_ERR),
      .TIMEOUT_ERR      (TIMEOUT_ERR)
   );

   // clock and cycle index (cycle n = interval after the n-th rising edge)
   initial begin
      PULSEPROG_CLK = 1'b0;
      forever #5 PULSEPROG_CLK = ~PULSEPROG_CLK;
   end

   initial begin
      forever begin
         @(posedge PULSEPROG_CLK);
         cyc++;
      end
   end

   // observer: records DUT events by cycle index, sampled mid-cycle
   initial begin
      forever begin
         @(negedge PULSEPROG_CLK);
         if (NMR_START === 1'b1) begin
            start_q.push_back(cyc);
            phase_q.push_back(int'(PHASE_CYCLE));
            idx_q.push_back(int'(SCAN_IDX));
         end
         if (SEQ_DONE === 1'b1) done_q.push_back(cyc);
         if (SEQ_BUSY === 1'b1) busy_cycles++;
         if (SAMPLE_ERR === 1'b1 && err_first < 0) err_first = cyc;
      end
   end

   // controller model: FSMSTAT high 40 cycles starting 2 cycles after START, beats inside
   initial begin
      NMR_FSMSTAT    = 1'b0;
      ADC_DATA_VALID = 1'b0;
      forever begin
         @(negedge PULSEPROG_CLK);
         if (NMR_START === 1'b1 && !mdl_noack) begin
            int b;
            b = beat_plan[mdl_scan % 8];
            mdl_scan++;
            @(posedge PULSEPROG_CLK);
            for (int i = 0; i < 40; i++) begin
               @(posedge PULSEPROG_CLK);
               #1;
               NMR_FSMSTAT    = 1'b1;
               ADC_DATA_VALID = (i >= 3) && (i < 3 + b);
            end
            @(posedge PULSEPROG_CLK);
            #1;
            NMR_FSMSTAT    = 1'b0;
            ADC_DATA_VALID = 1'b0;
            fall_q.push_back(cyc);
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge PULSEPROG_CLK);
      #1;
   endtask

   task automatic set_plan(input int b);
      for (int i = 0; i < 8; i++) beat_plan[i] = b;
   endtask

   task automatic start_seq(input int num, input int dly, input bit en, input int exp,
                            input bit with_abort, output int sc);
      start_q.delete(); phase_q.delete(); idx_q.delete(); done_q.delete(); fall_q.delete();
      busy_cycles      = 0;
      mdl_scan         = 0;
      NUM_SCANS        = 16'(num);
      SCAN_REP_DELAY   = 32'(dly);
      PHASE_CYCLE_EN   = en;
      EXPECTED_SAMPLES = 32'(exp);
      SEQ_START        = 1'b1;
      SEQ_ABORT        = with_abort;
      sc               = cyc;
      tick(1);
      SEQ_START = 1'b0;
      SEQ_ABORT = 1'b0;
      err_first = -1;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 3000 && done_q.size() == 0; i++) tick(1);
      chk("done_seen", done_q.size() != 0, 1);
      tick(3);
   endtask

   task automatic wait_starts(input int n, input string tag);
      for (int i = 0; i < 3000 && start_q.size() < n; i++) tick(1);
      chk(tag, start_q.size() >= n, 1);
   endtask

   // reference expectations for a run that completes all scans
   task automatic check_normal(input string tag, input int num, input int dly, input bit en,
                               input int exp, input int sc);
      int bad;
      chk({tag, "_nstart"}, start_q.size(), num);
      chk({tag, "_ndone"}, done_q.size(), 1);
      if (start_q.size() == num && fall_q.size() >= num && done_q.size() == 1) begin
         chk({tag, "_start_lat"}, start_q[0] - sc + 1, 2);
         for (int i = 0; i < num; i++) begin
            chk($sformatf("%s_phase%0d", tag, i), phase_q[i], en ? (i % 2) : 0);
            chk($sformatf("%s_idx%0d", tag, i), idx_q[i], i);
         end
         for (int i = 0; i + 1 < num; i++)
            chk($sformatf("%s_gap%0d", tag, i), start_q[i + 1] - fall_q[i], dly + 2);
         chk({tag, "_done_cyc"}, done_q[0], fall_q[num - 1] + 2);
         chk({tag, "_busy_len"}, busy_cycles, done_q[0] - sc);
         bad = -1;
         for (int j = num - 1; j >= 0; j--) if (beat_plan[j] != exp) bad = j;
         chk({tag, "_err_cyc"}, err_first, (bad < 0) ? -1 : fall_q[bad] + 2);
      end
      chk({tag, "_aborted"}, SEQ_ABORTED, 0);
      chk({tag, "_timeout"}, TIMEOUT_ERR, 0);
      chk({tag, "_busy_end"}, SEQ_BUSY, 0);
   endtask

   initial begin
      int sc;
      int c;
      int num;
      int dly;
      bit en;

      RESET_N = 1'b0; SEQ_START = 1'b0; SEQ_ABORT = 1'b0;
      NUM_SCANS = '0; SCAN_REP_DELAY = '0; PHASE_CYCLE_EN = 1'b0; EXPECTED_SAMPLES = '0;
      set_plan(30);
      tick(3);
      chk("reset_outs", {NMR_START, PHASE_CYCLE, SCAN_IDX, SEQ_BUSY, SEQ_DONE,
                         SEQ_ABORTED, SAMPLE_ERR, TIMEOUT_ERR}, 0);
      RESET_N = 1'b1;
      tick(2);

      // 1) four scans with phase cycling; a second SEQ_START mid-run must be ignored
      start_seq(4, 10, 1'b1, 30, 1'b0, sc);
      wait_starts(2, "t1_two_starts");
      SEQ_START = 1'b1; NUM_SCANS = 16'd1;
      tick(1);
      SEQ_START = 1'b0;
      wait_done();
      check_normal("t1", 4, 10, 1'b1, 30, sc);
      chk("t1_sample_err", SAMPLE_ERR, 0);

      // 2) zero scans
      start_seq(0, 10, 1'b1, 30, 1'b0, sc);
      wait_done();
      chk("t2_nstart", start_q.size(), 0);
      chk("t2_busy_len", busy_cycles, 1);
      if (done_q.size() == 1) chk("t2_done_lat", done_q[0] - sc + 1, 2);
      chk("t2_ndone", done_q.size(), 1);

      // 3) short beat count on the second of three scans
      set_plan(30);
      beat_plan[1] = 29;
      start_seq(3, 4, 1'b0, 30, 1'b0, sc);
      wait_done();
      check_normal("t3", 3, 4, 1'b0, 30, sc);
      chk("t3_sample_err", SAMPLE_ERR, 1);

      // 4a) abort during scan 1 WAIT_DONE
      set_plan(30);
      start_seq(5, 10, 1'b1, 30, 1'b0, sc);
      wait_starts(2, "t4a_two_starts");
      tick(10);
      SEQ_ABORT = 1'b1;
      tick(1);
      SEQ_ABORT = 1'b0;
      wait_done();
      chk("t4a_nstart", start_q.size(), 2);
      if (fall_q.size() >= 2 && done_q.size() >= 1) chk("t4a_done_cyc", done_q[0], fall_q[1] + 2);
      chk("t4a_aborted", SEQ_ABORTED, 1);
      chk("t4a_sample_err_cleared", SAMPLE_ERR, 0);

      // 4b) abort during the repetition delay
      start_seq(5, 20, 1'b1, 30, 1'b0, sc);
      for (int i = 0; i < 3000 && fall_q.size() == 0; i++) tick(1);
      tick(4);
      c = cyc;
      SEQ_ABORT = 1'b1;
      tick(1);
      SEQ_ABORT = 1'b0;
      wait_done();
      chk("t4b_nstart", start_q.size(), 1);
      if (done_q.size() >= 1) chk("t4b_done_cyc", done_q[0], c + 1);
      chk("t4b_aborted", SEQ_ABORTED, 1);

      // 5) controller never acknowledges
      mdl_noack = 1'b1;
      start_seq(3, 5, 1'b1, 30, 1'b0, sc);
      wait_done();
      mdl_noack = 1'b0;
      chk("t5_nstart", start_q.size(), 1);
      if (start_q.size() >= 1 && done_q.size() >= 1)
         chk("t5_timeout_lat", done_q[0] - start_q[0], ACK + 1);
      chk("t5_timeout_err", TIMEOUT_ERR, 1);
      chk("t5_aborted", SEQ_ABORTED, 0);
      chk("t5_busy_end", SEQ_BUSY, 0);

      // 6) reset in the middle of scan 1, then a clean run
      set_plan(30);
      beat_plan[0] = 29;
      start_seq(3, 2, 1'b1, 30, 1'b0, sc);
      chk("t6_timeout_cleared", TIMEOUT_ERR, 0);
      chk("t6_busy_after_start", SEQ_BUSY, 1);
      wait_starts(2, "t6_two_starts");
      tick(10);
      chk("t6_pre_idx", SCAN_IDX, 1);
      chk("t6_pre_phase", PHASE_CYCLE, 1);
      chk("t6_pre_sample_err", SAMPLE_ERR, 1);
      RESET_N = 1'b0;
      tick(1);
      chk("t6_reset_outs", {NMR_START, PHASE_CYCLE, SCAN_IDX, SEQ_BUSY, SEQ_DONE,
                            SEQ_ABORTED, SAMPLE_ERR, TIMEOUT_ERR}, 0);
      RESET_N = 1'b1;
      c = start_q.size();
      tick(60);
      chk("t6_no_start_after_reset", start_q.size(), c);
      set_plan(30);
      start_seq(2, 3, 1'b1, 30, 1'b0, sc);
      wait_done();
      check_normal("t6", 2, 3, 1'b1, 30, sc);

      // randomized runs; the first one also raises SEQ_ABORT together with SEQ_START
      for (int it = 0; it < 5; it++) begin
         num = int'($urandom_range(1, 4));
         dly = int'($urandom_range(0, 12));
         en  = 1'($urandom_range(0, 1));
         for (int i = 0; i < 8; i++)
            beat_plan[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(29, 31)) : 30;
         start_seq(num, dly, en, 30, it == 0, sc);
         wait_done();
         check_normal($sformatf("rnd%0d", it), num, dly, en, 30, sc);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
